// File: rtl/activation_pipe.sv
// activation_pipe: two-stage valid/ready activation (pass/relu/leaky/clip) with a saturating zero-output counter
module activation_pipe #(
    parameter int WIDTH      = 16,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             in_mode,
    input  logic [WIDTH-1:0]       clip_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]   zero_count,
    input  logic                   stats_clear
);
    localparam int ZW = $clog2(LANES + 1);
    logic                    s1_valid, s2_valid, s1_adv, s2_adv;
    logic [LANES*WIDTH-1:0]  s1_data, act_data;
    logic [1:0]              s1_mode;
    logic signed [WIDTH-1:0] s1_clip, clip_c, x, lk, y;
    logic [ZW-1:0]           act_zeros, s2_zeros;
    logic [CNT_WIDTH:0]      cnt_sum;
    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_clip  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_clip <= clip_val;
            end
        end
    end
    // Leaky shift is computed on its own so it stays arithmetic regardless of the mux around it
    always_comb begin
        act_data  = '0;
        act_zeros = '0;
        x         = '0;
        lk        = '0;
        y         = '0;
        clip_c    = s1_clip[WIDTH-1] ? '0 : s1_clip;
        for (int i = 0; i < LANES; i++) begin
            x  = s1_data[i*WIDTH +: WIDTH];
            lk = x >>> LEAK_SHIFT;
            y  = s1_mode == 2'b00 ? x :
                 !x[WIDTH-1]      ? ((s1_mode == 2'b11 && x > clip_c) ? clip_c : x) :
                 s1_mode == 2'b10 ? lk : '0;
            act_data[i*WIDTH +: WIDTH] = y;
            act_zeros = act_zeros + ZW'(y == '0);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            s2_zeros <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= act_data;
                s2_zeros <= act_zeros;
            end
        end
    end
    assign cnt_sum = {1'b0, zero_count} + {{(CNT_WIDTH + 1 - ZW){1'b0}}, s2_zeros};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_count <= '0;
        else if (stats_clear)
            zero_count <= '0;
        else if (s2_valid && out_ready)
            zero_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed checks of activation modes, flow control, zero counting and async reset
module tb_activation_pipe;
    localparam int W = 16, L = 4, CW = 4;
    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, stats_clear = 1'b0;
    logic           in_ready, out_valid;
    logic [L*W-1:0] in_data = '0, out_data;
    logic [1:0]     in_mode = '0;
    logic [W-1:0]   clip_val = '0;
    logic [CW-1:0]  zero_count;
    int             checks = 0, errors = 0;
    int             sent = 0, recv = 0, stalls = 0;
    logic           acc, del;

    activation_pipe #(.WIDTH(W), .LANES(L), .LEAK_SHIFT(3), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .clip_val(clip_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .zero_count(zero_count), .stats_clear(stats_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] beat(input int i);
        return pk(i + 1, 2 * i + 1, -(i + 1), 100);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input logic [63:0] d, input int c);
        in_valid = 1'b1;
        in_mode  = 2'(m);
        in_data  = d;
        clip_val = 16'(c);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_zero_count", 64'(zero_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #20 rst_n = 1'b1;
        tick();
        // relu with most-negative lane
        send(1, pk(5, -3, 0, -32768), 0);
        chk("t1_lat1", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", out_data, pk(5, 0, 0, 0));
        tick();
        chk("t1_zc", 64'(zero_count), 64'd3);
        chk("t1_drained", 64'(out_valid), 64'd0);
        // leaky: shift floors toward -inf
        send(2, pk(-16, -1, -9, 7), 0);
        tick();
        chk("t2_data", out_data, pk(-2, -1, -2, 7));
        tick();
        chk("t2_zc", 64'(zero_count), 64'd3);
        // clip, back to back with a negative ceiling on the second beat
        send(3, pk(10, 7, -4, 3), 7);
        send(3, pk(10, 1, 2, 3), -5);
        chk("t3_clip7", out_data, pk(7, 7, 0, 3));
        tick();
        chk("t3_clipneg", out_data, pk(0, 0, 0, 0));
        chk("t3_zc_a", 64'(zero_count), 64'd4);
        tick();
        chk("t3_zc_b", 64'(zero_count), 64'd8);
        // 10-beat pass stream with out_ready low in cycles 3..5
        for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = sent < 10;
            in_mode   = 2'd0;
            in_data   = beat(sent);
            #1;
            chk("t4_in_ready", 64'(in_ready), 64'(!((sent - recv) == 2 && !out_ready)));
            if (!in_ready) stalls++;
            if (out_valid) chk("t4_data", out_data, beat(recv));
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (acc) sent++;
            if (del) recv++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_delivered", 64'(recv), 64'd10);
        chk("t4_stalls", 64'(stalls), 64'd3);
        chk("t4_zc", 64'(zero_count), 64'd8);
        // saturation of the 4-bit counter, then clear racing a handshake
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("t5_clear", 64'(zero_count), 64'd0);
        for (int i = 0; i < 5; i++) send(1, pk(-1, -2, -3, -4), 0);
        tick();
        tick();
        chk("t5_sat", 64'(zero_count), 64'd15);
        send(1, pk(-1, -2, -3, -4), 0);
        tick();
        chk("t5_hs_valid", 64'(out_valid), 64'd1);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("t5_clear_wins", 64'(zero_count), 64'd0);
        // asynchronous reset with two beats in flight
        send(1, pk(-1, -1, -1, -1), 0);
        tick();
        tick();
        chk("t6_zc_pre", 64'(zero_count), 64'd4);
        out_ready = 1'b0;
        send(0, pk(1, 2, 3, 4), 0);
        send(0, pk(5, 6, 7, 8), 0);
        chk("t6_full_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_data", out_data, 64'd0);
        chk("t6_async_zc", 64'(zero_count), 64'd0);
        chk("t6_async_ready", 64'(in_ready), 64'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(0, pk(9, 10, 11, 12), 0);
        chk("t6_lat1", 64'(out_valid), 64'd0);
        tick();
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_data", out_data, pk(9, 10, 11, 12));
        tick();
        chk("t6_no_leftover", 64'(out_valid), 64'd0);
        chk("t6_zc_post", 64'(zero_count), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
